// File: rtl/gfx_mem_arbiter.sv
// Three-way Avalon-MM arbiter for the gfx memory master.
// Scanout has priority; frag/host round-robin; tag FIFO routes reads.
module gfx_mem_arbiter #(
  parameter int ADDR_BITS   = 26,
  parameter int DATA_BITS   = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] scan_address,
  input  logic                 scan_read,
  output logic                 scan_waitrequest,
  output logic                 scan_readdatavalid,
  input  logic [ADDR_BITS-1:0] frag_address,
  input  logic                 frag_read,
  input  logic                 frag_write,
  input  logic [DATA_BITS-1:0] frag_writedata,
  output logic                 frag_waitrequest,
  output logic                 frag_readdatavalid,
  input  logic [ADDR_BITS-1:0] host_address,
  input  logic                 host_read,
  input  logic                 host_write,
  input  logic [DATA_BITS-1:0] host_writedata,
  output logic                 host_waitrequest,
  output logic                 host_readdatavalid,
  output logic [DATA_BITS-1:0] readdata,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [DATA_BITS-1:0] mem_writedata,
  input  logic                 mem_waitrequest,
  input  logic                 mem_readdatavalid,
  input  logic [DATA_BITS-1:0] mem_readdata,
  output logic                 rsp_error
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam logic [PW:0] C_FULL = (PW+1)'(MAX_PENDING);
  localparam logic [1:0] ID_SCAN = 2'd0;
  localparam logic [1:0] ID_FRAG = 2'd1;
  localparam logic [1:0] ID_HOST = 2'd2;

  logic          r_locked;
  logic [1:0]    r_owner;
  logic          r_rr_host;
  logic [1:0]    r_tag [MAX_PENDING];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic          r_err;

  logic       w_full;
  logic       w_scan_el;
  logic       w_frag_el;
  logic       w_host_el;
  logic       w_gnt;
  logic [1:0] w_gid;
  logic       w_req_rd;
  logic       w_req_wr;
  logic       w_act;
  logic       w_acc;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_head;

  assign w_full    = (r_cnt == C_FULL);
  assign w_scan_el = scan_read & ~w_full;
  assign w_frag_el = frag_write | (frag_read & ~w_full);
  assign w_host_el = host_write | (host_read & ~w_full);

  always_comb begin
    w_gnt = 1'b0;
    w_gid = ID_SCAN;
    if (r_locked) begin
      w_gnt = 1'b1;
      w_gid = r_owner;
    end else if (w_scan_el) begin
      w_gnt = 1'b1;
      w_gid = ID_SCAN;
    end else if (r_rr_host) begin
      if (w_host_el) begin
        w_gnt = 1'b1;
        w_gid = ID_HOST;
      end else if (w_frag_el) begin
        w_gnt = 1'b1;
        w_gid = ID_FRAG;
      end
    end else begin
      if (w_frag_el) begin
        w_gnt = 1'b1;
        w_gid = ID_FRAG;
      end else if (w_host_el) begin
        w_gnt = 1'b1;
        w_gid = ID_HOST;
      end
    end
  end

  always_comb begin
    w_req_rd      = 1'b0;
    w_req_wr      = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (1'b1)
      (w_gid == ID_SCAN): begin
        w_req_rd    = scan_read;
        mem_address = scan_address;
      end
      (w_gid == ID_FRAG): begin
        w_req_rd      = frag_read;
        w_req_wr      = frag_write;
        mem_address   = frag_address;
        mem_writedata = frag_writedata;
      end
      (w_gid == ID_HOST): begin
        w_req_rd      = host_read;
        w_req_wr      = host_write;
        mem_address   = host_address;
        mem_writedata = host_writedata;
      end
      default: begin
        w_req_rd = 1'b0;
      end
    endcase
  end

  // An owner that drops its request while locked simply releases the lock.
  assign w_act  = rst_n & w_gnt & (w_req_rd | w_req_wr);
  assign w_acc  = w_act & ~mem_waitrequest;
  assign w_push = w_acc & w_req_rd;
  assign w_pop  = mem_readdatavalid & (r_cnt != '0);
  assign w_head = r_tag[r_rp];

  assign mem_read  = w_act & w_req_rd;
  assign mem_write = w_act & w_req_wr;

  assign scan_waitrequest =
    ~(w_act & (w_gid == ID_SCAN)) | mem_waitrequest;
  assign frag_waitrequest =
    ~(w_act & (w_gid == ID_FRAG)) | mem_waitrequest;
  assign host_waitrequest =
    ~(w_act & (w_gid == ID_HOST)) | mem_waitrequest;

  assign scan_readdatavalid = rst_n & w_pop & (w_head == ID_SCAN);
  assign frag_readdatavalid = rst_n & w_pop & (w_head == ID_FRAG);
  assign host_readdatavalid = rst_n & w_pop & (w_head == ID_HOST);
  assign readdata  = mem_readdata;
  assign rsp_error = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked  <= 1'b0;
      r_owner   <= ID_SCAN;
      r_rr_host <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_locked <= w_act & mem_waitrequest;
      if (w_act & mem_waitrequest)
        r_owner <= w_gid;
      if (w_acc & (w_gid == ID_FRAG))
        r_rr_host <= 1'b1;
      else if (w_acc & (w_gid == ID_HOST))
        r_rr_host <= 1'b0;
      if (mem_readdatavalid & (r_cnt == '0))
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < MAX_PENDING; i++)
        r_tag[i] <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wp] <= w_gid;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push & ~w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (~w_push & w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed bench for gfx_mem_arbiter.
// Inputs change on negedge; outputs sampled 1 time unit later.
module tb_gfx_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [25:0] scan_address;
  logic        scan_read;
  logic        scan_waitrequest;
  logic        scan_readdatavalid;
  logic [25:0] frag_address;
  logic        frag_read;
  logic        frag_write;
  logic [15:0] frag_writedata;
  logic        frag_waitrequest;
  logic        frag_readdatavalid;
  logic [25:0] host_address;
  logic        host_read;
  logic        host_write;
  logic [15:0] host_writedata;
  logic        host_waitrequest;
  logic        host_readdatavalid;
  logic [15:0] readdata;
  logic [25:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [15:0] mem_readdata;
  logic        rsp_error;

  int tests;
  int fails;
  logic [1:0] q[$];
  logic [2:0] waits;
  logic [2:0] valids;

  assign waits  = {scan_waitrequest, frag_waitrequest,
                   host_waitrequest};
  assign valids = {scan_readdatavalid, frag_readdatavalid,
                   host_readdatavalid};

  gfx_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .scan_address(scan_address), .scan_read(scan_read),
    .scan_waitrequest(scan_waitrequest),
    .scan_readdatavalid(scan_readdatavalid),
    .frag_address(frag_address), .frag_read(frag_read),
    .frag_write(frag_write), .frag_writedata(frag_writedata),
    .frag_waitrequest(frag_waitrequest),
    .frag_readdatavalid(frag_readdatavalid),
    .host_address(host_address), .host_read(host_read),
    .host_write(host_write), .host_writedata(host_writedata),
    .host_waitrequest(host_waitrequest),
    .host_readdatavalid(host_readdatavalid),
    .readdata(readdata),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata),
    .rsp_error(rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    scan_read = 0; frag_read = 0; frag_write = 0;
    host_read = 0; host_write = 0;
    mem_waitrequest = 0; mem_readdatavalid = 0;
    mem_readdata = 16'h0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    scan_read = 1; frag_write = 1; host_read = 1;
    mem_readdatavalid = 1;
    @(negedge clk); #1;
    tests++;
    if ({mem_read, mem_write} !== 2'b00) begin
      fails++;
      $display("FAIL reset_cmd: got %b want 00", {mem_read, mem_write});
    end
    tests++;
    if (waits !== 3'b111) begin
      fails++;
      $display("FAIL reset_wait: got %b want 111", waits);
    end
    tests++;
    if (valids !== 3'b000) begin
      fails++;
      $display("FAIL reset_valid: got %b want 000", valids);
    end
    tests++;
    if (rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: got %b want 0", rsp_error);
    end
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  task automatic test_scan_priority();
    logic [2:0] exp;
    scan_address = 26'h100; frag_address = 26'h200;
    host_address = 26'h300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      scan_read = 1; frag_read = 1; host_read = 1;
      #1;
      tests++;
      if (mem_read !== 1'b1 || mem_address !== 26'h100 ||
          waits !== 3'b011) begin
        fails++;
        $display("FAIL scan_prio%0d: rd=%b addr=%h wait=%b want 1 100 011",
                 i, mem_read, mem_address, waits);
      end
      q.push_back(2'd0);
    end
    @(negedge clk);
    scan_read = 0; #1;
    tests++;
    if (mem_address !== 26'h200 || waits !== 3'b101) begin
      fails++;
      $display("FAIL frag_after_scan: addr=%h wait=%b want 200 101",
               mem_address, waits);
    end
    q.push_back(2'd1);
    @(negedge clk); #1;
    tests++;
    if (mem_address !== 26'h300 || waits !== 3'b110) begin
      fails++;
      $display("FAIL host_after_frag: addr=%h wait=%b want 300 110",
               mem_address, waits);
    end
    q.push_back(2'd2);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      idle();
      mem_readdatavalid = 1;
      mem_readdata = 16'hA000 + 16'(i);
      #1;
      exp = 3'b100 >> q[0];
      tests++;
      if (valids !== exp || readdata !== 16'hA000 + 16'(i)) begin
        fails++;
        $display("FAIL scan_ret%0d: valid=%b data=%h want %b %h",
                 i, valids, readdata, exp, 16'hA000 + 16'(i));
      end
      void'(q.pop_front());
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_rr_writes();
    frag_address = 26'h210; host_address = 26'h310;
    frag_writedata = 16'h1111; host_writedata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      frag_write = 1; host_write = 1;
      #1;
      tests++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
          mem_writedata !== ((i % 2 == 0) ? 16'h1111 : 16'h2222) ||
          waits !== ((i % 2 == 0) ? 3'b101 : 3'b110)) begin
        fails++;
        $display("FAIL rr_write%0d: wr=%b rd=%b data=%h wait=%b",
                 i, mem_write, mem_read, mem_writedata, waits);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_lock();
    scan_address = 26'h120; host_address = 26'h320;
    host_writedata = 16'h3333;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      host_write = 1;
      scan_read = (c >= 1);
      mem_waitrequest = (c < 3);
      #1;
      tests++;
      if (mem_address !== 26'h320 || mem_write !== 1'b1 ||
          mem_read !== 1'b0 || mem_writedata !== 16'h3333 ||
          waits !== ((c < 3) ? 3'b111 : 3'b110)) begin
        fails++;
        $display("FAIL lock_c%0d: addr=%h wr=%b rd=%b wait=%b",
                 c, mem_address, mem_write, mem_read, waits);
      end
    end
    @(negedge clk);
    host_write = 0; mem_waitrequest = 0;
    #1;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 26'h120 ||
        waits !== 3'b011) begin
      fails++;
      $display("FAIL scan_after_lock: rd=%b addr=%h wait=%b want 1 120 011",
               mem_read, mem_address, waits);
    end
    @(negedge clk);
    idle();
    mem_readdatavalid = 1; mem_readdata = 16'h5A5A;
    #1;
    tests++;
    if (valids !== 3'b100 || readdata !== 16'h5A5A) begin
      fails++;
      $display("FAIL lock_ret: valid=%b data=%h want 100 5a5a",
               valids, readdata);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_fifo_full();
    logic [1:0] seq [8];
    logic [2:0] exp;
    logic [25:0] a;
    seq = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      a = 26'h400 + 26'(2 * i);
      scan_address = a; frag_address = a; host_address = a;
      scan_read = (seq[i] == 2'd0);
      frag_read = (seq[i] == 2'd1);
      host_read = (seq[i] == 2'd2);
      #1;
      exp = ~(3'b100 >> seq[i]);
      tests++;
      if (mem_read !== 1'b1 || mem_address !== a || waits !== exp) begin
        fails++;
        $display("FAIL fill%0d: rd=%b addr=%h wait=%b want 1 %h %b",
                 i, mem_read, mem_address, waits, a, exp);
      end
      q.push_back(seq[i]);
    end
    @(negedge clk);
    idle();
    frag_read = 1; frag_address = 26'h500;
    #1;
    tests++;
    if (mem_read !== 1'b0 || waits !== 3'b111) begin
      fails++;
      $display("FAIL full_stall: rd=%b wait=%b want 0 111",
               mem_read, waits);
    end
    @(negedge clk);
    mem_readdatavalid = 1; mem_readdata = 16'hB000;
    #1;
    exp = 3'b100 >> q[0];
    tests++;
    if (mem_read !== 1'b0 || frag_waitrequest !== 1'b1 ||
        valids !== exp) begin
      fails++;
      $display("FAIL full_pop_nobypass: rd=%b fw=%b valid=%b want 0 1 %b",
               mem_read, frag_waitrequest, valids, exp);
    end
    void'(q.pop_front());
    @(negedge clk);
    mem_readdata = 16'hB001;
    #1;
    exp = 3'b100 >> q[0];
    tests++;
    if (mem_read !== 1'b1 || frag_waitrequest !== 1'b0 ||
        valids !== exp || mem_address !== 26'h500) begin
      fails++;
      $display("FAIL push_pop: rd=%b fw=%b valid=%b want 1 0 %b",
               mem_read, frag_waitrequest, valids, exp);
    end
    void'(q.pop_front());
    q.push_back(2'd1);
    @(negedge clk);
    idle();
    host_read = 1; host_address = 26'h510;
    #1;
    tests++;
    if (mem_read !== 1'b1 || host_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL refill: rd=%b hw=%b want 1 0",
               mem_read, host_waitrequest);
    end
    q.push_back(2'd2);
    @(negedge clk); #1;
    tests++;
    if (mem_read !== 1'b0 || waits !== 3'b111) begin
      fails++;
      $display("FAIL refull_stall: rd=%b wait=%b want 0 111",
               mem_read, waits);
    end
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      idle();
      mem_readdatavalid = 1;
      mem_readdata = 16'hC000 + 16'(i);
      #1;
      exp = 3'b100 >> q[0];
      tests++;
      if (valids !== exp || readdata !== 16'hC000 + 16'(i)) begin
        fails++;
        $display("FAIL drain%0d: valid=%b data=%h want %b",
                 i, valids, readdata, exp);
      end
      void'(q.pop_front());
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_rsp_error();
    @(negedge clk); #1;
    tests++;
    if (rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL err_clean: got %b want 0", rsp_error);
    end
    @(negedge clk);
    mem_readdatavalid = 1; mem_readdata = 16'hDEAD;
    #1;
    tests++;
    if (valids !== 3'b000) begin
      fails++;
      $display("FAIL stray_valid: got %b want 000", valids);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (rsp_error !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got %b want 1", rsp_error);
    end
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (rsp_error !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b want 1", rsp_error);
    end
    #1 rst_n = 0;
    #1;
    tests++;
    if (rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL err_async_clr: got %b want 0", rsp_error);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    scan_read = 1; scan_address = 26'h600;
    #1;
    tests++;
    if (mem_read !== 1'b1 || scan_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_read: rd=%b sw=%b want 1 0",
               mem_read, scan_waitrequest);
    end
    @(negedge clk);
    idle();
    #2 rst_n = 0;
    #1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_readdatavalid = 1; mem_readdata = 16'hBEEF;
    #1;
    tests++;
    if (valids !== 3'b000) begin
      fails++;
      $display("FAIL inflight_valid: got %b want 000", valids);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (rsp_error !== 1'b1) begin
      fails++;
      $display("FAIL inflight_err: got %b want 1", rsp_error);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    scan_address = '0; frag_address = '0; host_address = '0;
    frag_writedata = '0; host_writedata = '0;
    idle();
    rst_n = 0;
    test_reset();
    test_scan_priority();
    test_rr_writes();
    test_lock();
    test_fifo_full();
    test_rsp_error();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
